// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage: FSM states,
// datapath width, reset PC and word-address arithmetic.
package fetch_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      HOLD,
      DRAIN
   } fetch_state_e;

   // Instruction addresses are always word aligned; low bits are dropped on use.
   function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] a);
      return a & {{(INSTR_W-2){1'b1}}, 2'b00};
   endfunction

   // Wraps modulo 2^INSTR_W.
   function automatic logic [INSTR_W-1:0] pc_inc(input logic [INSTR_W-1:0] a);
      return a + INSTR_W'(4);
   endfunction

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory bus: single outstanding request, held until acknowledged.
interface instr_fetch_stage_if;
   import fetch_pkg::*;

   logic               imem_req;
   logic [INSTR_W-1:0] imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush clears only the valid bit and beats load;
// with neither asserted every field holds.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load,
   input  logic               i_flush,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic [INSTR_W-1:0] i_pc,
   output logic               o_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [INSTR_W-1:0] o_pc,
   output logic [INSTR_W-1:0] o_pcplus4
);

   logic               valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [INSTR_W-1:0] pc_q;
   logic [INSTR_W-1:0] pcplus4_q;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q   <= 1'b0;
         instr_q   <= '0;
         pc_q      <= '0;
         pcplus4_q <= '0;
      end else if (i_flush) begin
         valid_q   <= 1'b0;
      end else if (i_load) begin
         valid_q   <= 1'b1;
         instr_q   <= i_instr;
         pc_q      <= i_pc;
         pcplus4_q <= pc_inc(i_pc);
      end
   end

   assign o_valid   = valid_q;
   assign o_instr   = instr_q;
   assign o_pc      = pc_q;
   assign o_pcplus4 = pcplus4_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding imem requester, one-entry skid buffer for
// decode stalls, and redirect handling with discard of in-flight responses.
module instr_fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_stall,
   input  logic                i_redirect,
   input  logic [INSTR_W-1:0]  i_redirect_pc,
   instr_fetch_stage_if.master imem,
   output logic                o_valid,
   output logic [INSTR_W-1:0]  o_instr,
   output logic [INSTR_W-1:0]  o_pc,
   output logic [INSTR_W-1:0]  o_pcplus4
);

   fetch_state_e       state_q, state_d;
   logic [INSTR_W-1:0] pc_q, pc_d;
   logic [INSTR_W-1:0] tgt_q, tgt_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_pc_q;
   logic               skid_we;
   logic               ifid_load, ifid_flush;
   logic [INSTR_W-1:0] ifid_instr, ifid_pc;
   logic [INSTR_W-1:0] redirect_pc;

   assign redirect_pc = word_align(i_redirect_pc);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // NOTE: skid and saved target are data-only; the FSM never reads them before writing, so no reset.
   always_ff @(posedge i_clk) begin
      tgt_q <= tgt_d;
      if (skid_we) begin
         skid_instr_q <= imem.imem_rdata;
         skid_pc_q    <= pc_q;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      tgt_d      = tgt_q;
      skid_we    = 1'b0;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_instr = imem.imem_rdata;
      ifid_pc    = pc_q;

      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (i_redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
            end
         end

         REQ: begin
            if (i_redirect) begin
               ifid_flush = 1'b1;
               if (imem.imem_ack) begin
                  pc_d = redirect_pc;
               end else begin
                  tgt_d   = redirect_pc;
                  state_d = DRAIN;
               end
            end else if (imem.imem_ack) begin
               pc_d = pc_inc(pc_q);
               if (i_stall) begin
                  skid_we = 1'b1;
                  state_d = HOLD;
               end else begin
                  ifid_load = 1'b1;
               end
            end else if (!i_stall) begin
               ifid_flush = 1'b1;
            end
         end

         HOLD: begin
            ifid_instr = skid_instr_q;
            ifid_pc    = skid_pc_q;
            if (i_redirect) begin
               pc_d       = redirect_pc;
               ifid_flush = 1'b1;
               state_d    = REQ;
            end else if (!i_stall) begin
               ifid_load = 1'b1;
               state_d   = REQ;
            end
         end

         DRAIN: begin
            // The outstanding request must complete at its old address; its data is dropped.
            ifid_flush = 1'b1;
            if (i_redirect) begin
               tgt_d = redirect_pc;
            end
            if (imem.imem_ack) begin
               pc_d    = i_redirect ? redirect_pc : tgt_q;
               state_d = REQ;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
   assign imem.imem_addr = word_align(pc_q);

   if_id_reg u_if_id_reg (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (ifid_load),
      .i_flush   (ifid_flush),
      .i_instr   (ifid_instr),
      .i_pc      (ifid_pc),
      .o_valid   (o_valid),
      .o_instr   (o_instr),
      .o_pc      (o_pc),
      .o_pcplus4 (o_pcplus4)
   );

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a per-cycle vector table over a memory
// model whose words equal their addresses, plus hand-written reset/drain sequences.
module tb_instr_fetch_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        valid;
   logic [31:0] instr, pc, pcplus4;

   int          mem_lat = 0;
   int          wait_cnt;
   logic        ack_force = 1'b0;
   logic        model_ack;

   int          n_checks = 0;
   int          n_fail = 0;

   instr_fetch_stage_if imem_bus ();

   instr_fetch_stage dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_stall       (stall),
      .i_redirect    (redirect),
      .i_redirect_pc (redirect_pc),
      .imem          (imem_bus),
      .o_valid       (valid),
      .o_instr       (instr),
      .o_pc          (pc),
      .o_pcplus4     (pcplus4)
   );

   always #5 clk = ~clk;

   // Memory model: acks after mem_lat waiting cycles (0 = same cycle as req), word = address.
   assign model_ack           = imem_bus.imem_req && (wait_cnt == mem_lat);
   assign imem_bus.imem_ack   = model_ack | ack_force;
   assign imem_bus.imem_rdata = imem_bus.imem_addr;

   always @(posedge clk or posedge rst) begin
      if (rst)                                 wait_cnt <= 0;
      else if (imem_bus.imem_req && !model_ack) wait_cnt <= wait_cnt + 1;
      else                                     wait_cnt <= 0;
   end

   typedef struct {
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      int          lat;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t row(input logic s, input logic r, input logic [31:0] rp,
                                input int l, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
      vec_t v;
      v.stall = s; v.redir = r; v.rpc = rp; v.lat = l;
      v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic check_outputs(input string tag, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
      check({tag, " req"},   {31'b0, imem_bus.imem_req}, {31'b0, er});
      check({tag, " addr"},  imem_bus.imem_addr, ea);
      check({tag, " valid"}, {31'b0, valid}, {31'b0, ev});
      if (ev) begin
         check({tag, " pc"},      pc, ep);
         check({tag, " instr"},   instr, ep);
         check({tag, " pcplus4"}, pcplus4, ep + 32'd4);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " req"},     {31'b0, imem_bus.imem_req}, 32'h0);
      check({tag, " addr"},    imem_bus.imem_addr, 32'h0);
      check({tag, " valid"},   {31'b0, valid}, 32'h0);
      check({tag, " instr"},   instr, 32'h0);
      check({tag, " pc"},      pc, 32'h0);
      check({tag, " pcplus4"}, pcplus4, 32'h0);
   endtask

   task automatic step(input string tag, input logic s, input logic r, input logic [31:0] rp,
                       input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
      @(posedge clk);
      #2;
      ack_force   = 1'b0;
      stall       = s;
      redirect    = r;
      redirect_pc = rp;
      #1;
      check_outputs(tag, er, ea, ev, ep);
   endtask

   initial begin
      // Cycle-by-cycle vectors starting at cycle 1 after reset release.
      //                 stall redir rpc           lat  req addr          valid pc
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h00,       0, 32'h0));        // c1
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h04,       1, 32'h00));       // c2
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h08,       1, 32'h04));
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h0C,       1, 32'h08));
      vecs.push_back(row(1, 0, 32'h0,        0, 1, 32'h10,       1, 32'h0C));       // c5 stall+ack
      vecs.push_back(row(1, 0, 32'h0,        0, 0, 32'h14,       1, 32'h0C));
      vecs.push_back(row(1, 0, 32'h0,        0, 0, 32'h14,       1, 32'h0C));
      vecs.push_back(row(0, 0, 32'h0,        0, 0, 32'h14,       1, 32'h0C));       // c8 release
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h14,       1, 32'h10));
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h18,       1, 32'h14));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h1C,       1, 32'h18));       // c11 lat 2
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h1C,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h1C,       0, 32'h0));
      vecs.push_back(row(0, 1, 32'h40,       2, 1, 32'h20,       1, 32'h1C));       // c14 redirect
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h20,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h20,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h40,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h40,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        2, 1, 32'h40,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h44,       1, 32'h40));       // c20
      vecs.push_back(row(1, 0, 32'h0,        0, 1, 32'h48,       1, 32'h44));       // c21 into HOLD
      vecs.push_back(row(1, 1, 32'h80,       0, 0, 32'h4C,       1, 32'h44));       // c22 flush wins
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h80,       0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h84,       1, 32'h80));
      vecs.push_back(row(0, 1, 32'hFFFF_FFFC, 0, 1, 32'h88,      1, 32'h84));       // c25
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 32'h0));
      vecs.push_back(row(0, 1, 32'h103,      0, 1, 32'h0,        1, 32'hFFFF_FFFC)); // c27 wrap
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h100,      0, 32'h0));
      vecs.push_back(row(0, 0, 32'h0,        0, 1, 32'h104,      1, 32'h100));

      repeat (2) @(posedge clk);
      #2;
      check_reset_values("reset");
      rst = 1'b0;
      #1;
      check_outputs("c0", 1'b0, 32'h0, 1'b0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clk);
         #2;
         stall       = vecs[i].stall;
         redirect    = vecs[i].redir;
         redirect_pc = vecs[i].rpc;
         mem_lat     = vecs[i].lat;
         #1;
         check_outputs($sformatf("c%0d", i + 1), vecs[i].exp_req, vecs[i].exp_addr,
                       vecs[i].exp_valid, vecs[i].exp_pc);
      end

      // Reset mid-request, then a stray ack while idle must be ignored.
      @(posedge clk);
      #2;
      stall    = 1'b0;
      redirect = 1'b0;
      mem_lat  = 3;
      #1;
      rst = 1'b1;
      #1;
      check_reset_values("midreset");
      @(posedge clk);
      #2;
      rst       = 1'b0;
      ack_force = 1'b1;
      #1;
      check_outputs("r0", 1'b0, 32'h0, 1'b0, 32'h0);
      step("r1", 0, 0, 32'h0,   1, 32'h0, 0, 32'h0);
      step("r2", 0, 0, 32'h0,   1, 32'h0, 0, 32'h0);
      step("r3", 0, 0, 32'h0,   1, 32'h0, 0, 32'h0);
      step("r4", 0, 0, 32'h0,   1, 32'h0, 0, 32'h0);
      // Redirect during DRAIN replaces the saved target.
      step("r5", 0, 1, 32'h200, 1, 32'h4, 1, 32'h0);
      step("r6", 0, 1, 32'h300, 1, 32'h4, 0, 32'h0);
      step("r7", 0, 0, 32'h0,   1, 32'h4, 0, 32'h0);
      step("r8", 0, 0, 32'h0,   1, 32'h4, 0, 32'h0);
      step("r9", 0, 0, 32'h0,   1, 32'h300, 0, 32'h0);
      step("r10", 0, 0, 32'h0,  1, 32'h300, 0, 32'h0);
      step("r11", 0, 0, 32'h0,  1, 32'h300, 0, 32'h0);
      step("r12", 0, 0, 32'h0,  1, 32'h300, 0, 32'h0);
      step("r13", 0, 0, 32'h0,  1, 32'h304, 1, 32'h300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
